// File: rtl/reg_to_axi_tmo_if.sv
// Bus interfaces for reg_to_axi_tmo: a register request/response port and a
// single-beat AXI master port. Parameter names mirror the bridge parameters.
interface reg_to_axi_tmo_reg_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic [AddrWidth-1:0]   reg_req_addr;
    logic [DataWidth-1:0]   reg_req_wdata;
    logic [DataWidth/8-1:0] reg_req_wstrb;
    logic                   reg_req_write;
    logic                   reg_req_valid;
    logic [DataWidth-1:0]   reg_rsp_rdata;
    logic                   reg_rsp_error;
    logic                   reg_rsp_ready;

    modport master (
        output reg_req_addr, reg_req_wdata, reg_req_wstrb, reg_req_write, reg_req_valid,
        input  reg_rsp_rdata, reg_rsp_error, reg_rsp_ready
    );
    modport slave (
        input  reg_req_addr, reg_req_wdata, reg_req_wstrb, reg_req_write, reg_req_valid,
        output reg_rsp_rdata, reg_rsp_error, reg_rsp_ready
    );
endinterface

interface reg_to_axi_tmo_axi_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 2
);
    logic [IdWidth-1:0]     axi_aw_id;
    logic [AddrWidth-1:0]   axi_aw_addr;
    logic [2:0]             axi_aw_size;
    logic                   axi_aw_valid;
    logic                   axi_aw_ready;
    logic [DataWidth-1:0]   axi_w_data;
    logic [DataWidth/8-1:0] axi_w_strb;
    logic                   axi_w_last;
    logic                   axi_w_valid;
    logic                   axi_w_ready;
    logic [IdWidth-1:0]     axi_b_id;
    logic [1:0]             axi_b_resp;
    logic                   axi_b_valid;
    logic                   axi_b_ready;
    logic [IdWidth-1:0]     axi_ar_id;
    logic [AddrWidth-1:0]   axi_ar_addr;
    logic [2:0]             axi_ar_size;
    logic                   axi_ar_valid;
    logic                   axi_ar_ready;
    logic [IdWidth-1:0]     axi_r_id;
    logic [DataWidth-1:0]   axi_r_data;
    logic [1:0]             axi_r_resp;
    logic                   axi_r_last;
    logic                   axi_r_valid;
    logic                   axi_r_ready;

    modport master (
        output axi_aw_id, axi_aw_addr, axi_aw_size, axi_aw_valid, input axi_aw_ready,
        output axi_w_data, axi_w_strb, axi_w_last, axi_w_valid, input axi_w_ready,
        input  axi_b_id, axi_b_resp, axi_b_valid, output axi_b_ready,
        output axi_ar_id, axi_ar_addr, axi_ar_size, axi_ar_valid, input axi_ar_ready,
        input  axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid, output axi_r_ready
    );
    modport slave (
        input  axi_aw_id, axi_aw_addr, axi_aw_size, axi_aw_valid, output axi_aw_ready,
        input  axi_w_data, axi_w_strb, axi_w_last, axi_w_valid, output axi_w_ready,
        output axi_b_id, axi_b_resp, axi_b_valid, input axi_b_ready,
        input  axi_ar_id, axi_ar_addr, axi_ar_size, axi_ar_valid, output axi_ar_ready,
        output axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid, input axi_r_ready
    );
endinterface

// File: rtl/reg_to_axi_tmo.sv
// Register-bus to AXI bridge issuing one single-beat transaction per request.
// Optional wait-state timeout enabled by defining REG_TO_AXI_TIMEOUT_EN.
module reg_to_axi_tmo #(
    parameter int AxiDataWidth  = 64,
    parameter int AxiAddrWidth  = 64,
    parameter int AxiIdWidth    = 2,
    parameter int TimeoutCycles = 1024
) (
    input logic                  clk_i,
    input logic                  rst_i,
    reg_to_axi_tmo_reg_if.slave  reg_bus,
    reg_to_axi_tmo_axi_if.master axi
);
    localparam logic [2:0] AxiSize = 3'($clog2(AxiDataWidth / 8));

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WREQ = 3'd1,
        WRSP = 3'd2,
        RREQ = 3'd3,
        RRSP = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                    state_r, state_s;
    logic [AxiIdWidth-1:0]     tag_r, tag_s;
    logic [AxiIdWidth-1:0]     cur_tag_r, cur_tag_s;
    logic [AxiAddrWidth-1:0]   addr_r, addr_s;
    logic [AxiDataWidth-1:0]   wdata_r, wdata_s;
    logic [AxiDataWidth/8-1:0] wstrb_r, wstrb_s;
    logic                      aw_valid_r, aw_valid_s;
    logic                      w_valid_r, w_valid_s;
    logic                      ar_valid_r, ar_valid_s;
    logic                      rsp_ready_r, rsp_ready_s;
    logic                      rsp_error_r, rsp_error_s;
    logic [AxiDataWidth-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic                      unused_r_last_s;

`ifdef REG_TO_AXI_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] cnt_r, cnt_s;
`endif

    assign unused_r_last_s = axi.axi_r_last;

    // Next-state and next-output computation for the bridge FSM.
    always_comb begin
        state_s     = state_r;
        tag_s       = tag_r;
        cur_tag_s   = cur_tag_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        wstrb_s     = wstrb_r;
        aw_valid_s  = aw_valid_r;
        w_valid_s   = w_valid_r;
        ar_valid_s  = ar_valid_r;
        rsp_ready_s = 1'b0;
        rsp_error_s = rsp_error_r;
        rsp_rdata_s = rsp_rdata_r;
        case (state_r)
            IDLE: begin
                if (reg_bus.reg_req_valid) begin
                    addr_s    = reg_bus.reg_req_addr;
                    wdata_s   = reg_bus.reg_req_wdata;
                    wstrb_s   = reg_bus.reg_req_wstrb;
                    cur_tag_s = tag_r;
                    tag_s     = tag_r + AxiIdWidth'(1);
                    if (reg_bus.reg_req_write) begin
                        state_s    = WREQ;
                        aw_valid_s = 1'b1;
                        w_valid_s  = 1'b1;
                    end else begin
                        state_s    = RREQ;
                        ar_valid_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WREQ: begin
                // AW and W retire independently; both may complete in one cycle.
                if (aw_valid_r && axi.axi_aw_ready) begin
                    aw_valid_s = 1'b0;
                end else begin
                    aw_valid_s = aw_valid_r;
                end
                if (w_valid_r && axi.axi_w_ready) begin
                    w_valid_s = 1'b0;
                end else begin
                    w_valid_s = w_valid_r;
                end
                if (!aw_valid_s && !w_valid_s) begin
                    state_s = WRSP;
                end else begin
                    state_s = WREQ;
                end
            end
            WRSP: begin
                if (axi.axi_b_valid && (axi.axi_b_id == cur_tag_r)) begin
                    state_s     = DONE;
                    rsp_ready_s = 1'b1;
                    rsp_error_s = axi.axi_b_resp[1];
                    rsp_rdata_s = '0;
                end else begin
                    state_s = WRSP;
                end
            end
            RREQ: begin
                if (axi.axi_ar_ready) begin
                    ar_valid_s = 1'b0;
                    state_s    = RRSP;
                end else begin
                    state_s = RREQ;
                end
            end
            RRSP: begin
                if (axi.axi_r_valid && (axi.axi_r_id == cur_tag_r)) begin
                    state_s     = DONE;
                    rsp_ready_s = 1'b1;
                    rsp_error_s = axi.axi_r_resp[1];
                    rsp_rdata_s = axi.axi_r_data;
                end else begin
                    state_s = RRSP;
                end
            end
            DONE: begin
                state_s     = IDLE;
                rsp_error_s = 1'b0;
                rsp_rdata_s = '0;
            end
            default: begin
                state_s    = IDLE;
                aw_valid_s = 1'b0;
                w_valid_s  = 1'b0;
                ar_valid_s = 1'b0;
            end
        endcase
`ifdef REG_TO_AXI_TIMEOUT_EN
        cnt_s = '0;
        // Timeout overrides any handshake seen in the same cycle.
        if ((state_r != IDLE) && (state_r != DONE)) begin
            if (cnt_r == CntWidth'(TimeoutCycles - 1)) begin
                cnt_s       = cnt_r;
                state_s     = DONE;
                aw_valid_s  = 1'b0;
                w_valid_s   = 1'b0;
                ar_valid_s  = 1'b0;
                rsp_ready_s = 1'b1;
                rsp_error_s = 1'b1;
                rsp_rdata_s = '0;
            end else begin
                cnt_s = cnt_r + CntWidth'(1);
            end
        end else begin
            cnt_s = '0;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            tag_r       <= '0;
            cur_tag_r   <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            aw_valid_r  <= 1'b0;
            w_valid_r   <= 1'b0;
            ar_valid_r  <= 1'b0;
            rsp_ready_r <= 1'b0;
            rsp_error_r <= 1'b0;
            rsp_rdata_r <= '0;
`ifdef REG_TO_AXI_TIMEOUT_EN
            cnt_r       <= '0;
`endif
        end else begin
            state_r     <= state_s;
            tag_r       <= tag_s;
            cur_tag_r   <= cur_tag_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            wstrb_r     <= wstrb_s;
            aw_valid_r  <= aw_valid_s;
            w_valid_r   <= w_valid_s;
            ar_valid_r  <= ar_valid_s;
            rsp_ready_r <= rsp_ready_s;
            rsp_error_r <= rsp_error_s;
            rsp_rdata_r <= rsp_rdata_s;
`ifdef REG_TO_AXI_TIMEOUT_EN
            cnt_r       <= cnt_s;
`endif
        end
    end

    assign reg_bus.reg_rsp_rdata = rsp_rdata_r;
    assign reg_bus.reg_rsp_error = rsp_error_r;
    assign reg_bus.reg_rsp_ready = rsp_ready_r;

    assign axi.axi_aw_id    = cur_tag_r;
    assign axi.axi_aw_addr  = addr_r;
    assign axi.axi_aw_size  = AxiSize;
    assign axi.axi_aw_valid = aw_valid_r;
    assign axi.axi_w_data   = wdata_r;
    assign axi.axi_w_strb   = wstrb_r;
    assign axi.axi_w_last   = 1'b1;
    assign axi.axi_w_valid  = w_valid_r;
    assign axi.axi_ar_id    = cur_tag_r;
    assign axi.axi_ar_addr  = addr_r;
    assign axi.axi_ar_size  = AxiSize;
    assign axi.axi_ar_valid = ar_valid_r;
    // Responses are drained everywhere except while the reg response is shown.
    assign axi.axi_b_ready  = (state_r != DONE);
    assign axi.axi_r_ready  = (state_r != DONE);
endmodule

// File: tb/tb_reg_to_axi_tmo.sv
// Directed self-checking bench for reg_to_axi_tmo (64-bit data/address, 2-bit id,
// 16-cycle timeout when REG_TO_AXI_TIMEOUT_EN is defined).
module tb_reg_to_axi_tmo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   aw_hs_cnt = 0;
    int   w_hs_cnt = 0;
    int   pulse_cnt = 0;
    logic [1:0] exp_tag;

    always #5 clk = ~clk;

    reg_to_axi_tmo_reg_if #(.AddrWidth(64), .DataWidth(64)) reg_bus ();
    reg_to_axi_tmo_axi_if #(.AddrWidth(64), .DataWidth(64), .IdWidth(2)) axi ();

    reg_to_axi_tmo #(
        .AxiDataWidth (64),
        .AxiAddrWidth (64),
        .AxiIdWidth   (2),
        .TimeoutCycles(16)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .reg_bus(reg_bus),
        .axi    (axi)
    );

    // Handshake and response-pulse counters.
    always @(posedge clk) begin
        if (!rst) begin
            if (axi.axi_aw_valid && axi.axi_aw_ready) aw_hs_cnt <= aw_hs_cnt + 1;
            if (axi.axi_w_valid && axi.axi_w_ready) w_hs_cnt <= w_hs_cnt + 1;
            if (reg_bus.reg_rsp_ready) pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           input logic wr);
        reg_bus.reg_req_addr  = a;
        reg_bus.reg_req_wdata = d;
        reg_bus.reg_req_wstrb = s;
        reg_bus.reg_req_write = wr;
        reg_bus.reg_req_valid = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_aw_valid"}, 64'(axi.axi_aw_valid), 64'd0);
        check_eq({tag, "_w_valid"}, 64'(axi.axi_w_valid), 64'd0);
        check_eq({tag, "_ar_valid"}, 64'(axi.axi_ar_valid), 64'd0);
        check_eq({tag, "_rsp_ready"}, 64'(reg_bus.reg_rsp_ready), 64'd0);
        check_eq({tag, "_rsp_error"}, 64'(reg_bus.reg_rsp_error), 64'd0);
        check_eq({tag, "_rsp_rdata"}, reg_bus.reg_rsp_rdata, 64'd0);
        check_eq({tag, "_b_ready"}, 64'(axi.axi_b_ready), 64'd1);
    endtask

    // Write with AW and W accepted together, then a B with the given response.
    task automatic do_write(input logic [63:0] a, input logic [1:0] resp, input logic [1:0] id);
        set_req(a, ~a, 8'h0F, 1'b1);
        tick();
        check_eq("wr_aw_id", 64'(axi.axi_aw_id), 64'(id));
        check_eq("wr_aw_addr", axi.axi_aw_addr, a);
        check_eq("wr_both_valid", 64'({axi.axi_aw_valid, axi.axi_w_valid}), 64'd3);
        axi.axi_aw_ready = 1'b1;
        axi.axi_w_ready  = 1'b1;
        tick();
        axi.axi_aw_ready = 1'b0;
        axi.axi_w_ready  = 1'b0;
        check_eq("wr_both_dropped", 64'({axi.axi_aw_valid, axi.axi_w_valid}), 64'd0);
        axi.axi_b_valid = 1'b1;
        axi.axi_b_id    = id;
        axi.axi_b_resp  = resp;
        tick();
        axi.axi_b_valid = 1'b0;
        check_eq("wr_rsp_ready", 64'(reg_bus.reg_rsp_ready), 64'd1);
        check_eq("wr_rsp_error", 64'(reg_bus.reg_rsp_error), 64'(resp[1]));
        reg_bus.reg_req_valid = 1'b0;
        tick();
        check_eq("wr_ready_drop", 64'(reg_bus.reg_rsp_ready), 64'd0);
    endtask

    initial begin
        int n;
        int p;
        reg_bus.reg_req_addr  = '0;
        reg_bus.reg_req_wdata = '0;
        reg_bus.reg_req_wstrb = '0;
        reg_bus.reg_req_write = 1'b0;
        reg_bus.reg_req_valid = 1'b0;
        axi.axi_aw_ready = 1'b0;
        axi.axi_w_ready  = 1'b0;
        axi.axi_b_id     = '0;
        axi.axi_b_resp   = '0;
        axi.axi_b_valid  = 1'b0;
        axi.axi_ar_ready = 1'b0;
        axi.axi_r_id     = '0;
        axi.axi_r_data   = '0;
        axi.axi_r_resp   = '0;
        axi.axi_r_last   = 1'b1;
        axi.axi_r_valid  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");
        check_eq("reset_r_ready", 64'(axi.axi_r_ready), 64'd1);

        // Write: AW accepted one cycle before W, OKAY response.
        set_req(64'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
        tick();
        check_eq("w1_aw_valid", 64'(axi.axi_aw_valid), 64'd1);
        check_eq("w1_w_valid", 64'(axi.axi_w_valid), 64'd1);
        check_eq("w1_aw_id", 64'(axi.axi_aw_id), 64'd0);
        check_eq("w1_aw_size", 64'(axi.axi_aw_size), 64'd3);
        check_eq("w1_w_data", axi.axi_w_data, 64'hDEADBEEF_CAFEF00D);
        check_eq("w1_w_strb", 64'(axi.axi_w_strb), 64'hFF);
        check_eq("w1_w_last", 64'(axi.axi_w_last), 64'd1);
        axi.axi_aw_ready = 1'b1;
        tick();
        axi.axi_aw_ready = 1'b0;
        check_eq("w1_aw_dropped", 64'(axi.axi_aw_valid), 64'd0);
        check_eq("w1_w_held", 64'(axi.axi_w_valid), 64'd1);
        check_eq("w1_w_data_stable", axi.axi_w_data, 64'hDEADBEEF_CAFEF00D);
        axi.axi_w_ready = 1'b1;
        tick();
        axi.axi_w_ready = 1'b0;
        check_eq("w1_w_dropped", 64'(axi.axi_w_valid), 64'd0);
        axi.axi_b_valid = 1'b1;
        axi.axi_b_id    = 2'd0;
        axi.axi_b_resp  = 2'b00;
        tick();
        axi.axi_b_valid = 1'b0;
        check_eq("w1_rsp_ready", 64'(reg_bus.reg_rsp_ready), 64'd1);
        check_eq("w1_rsp_error", 64'(reg_bus.reg_rsp_error), 64'd0);
        check_eq("w1_rsp_rdata", reg_bus.reg_rsp_rdata, 64'd0);
        check_eq("w1_b_ready_done", 64'(axi.axi_b_ready), 64'd0);
        reg_bus.reg_req_valid = 1'b0;
        tick();
        check_eq("w1_ready_pulse", 64'(reg_bus.reg_rsp_ready), 64'd0);
        check_eq("w1_aw_count", 64'(aw_hs_cnt), 64'd1);
        check_eq("w1_w_count", 64'(w_hs_cnt), 64'd1);
        check_eq("w1_pulse_count", 64'(pulse_cnt), 64'd1);

        // Read with a 3-cycle AR stall and a SLVERR response.
        set_req(64'h1000, 64'd0, 8'h00, 1'b0);
        tick();
        check_eq("r1_ar_valid", 64'(axi.axi_ar_valid), 64'd1);
        check_eq("r1_ar_addr", axi.axi_ar_addr, 64'h1000);
        check_eq("r1_ar_id", 64'(axi.axi_ar_id), 64'd1);
        check_eq("r1_ar_size", 64'(axi.axi_ar_size), 64'd3);
        for (int i = 0; i < 3; i++) tick();
        check_eq("r1_ar_stalled", 64'(axi.axi_ar_valid), 64'd1);
        check_eq("r1_ar_addr_stable", axi.axi_ar_addr, 64'h1000);
        axi.axi_ar_ready = 1'b1;
        tick();
        axi.axi_ar_ready = 1'b0;
        check_eq("r1_ar_dropped", 64'(axi.axi_ar_valid), 64'd0);
        axi.axi_r_valid = 1'b1;
        axi.axi_r_id    = 2'd1;
        axi.axi_r_data  = 64'h0123_4567_89AB_CDEF;
        axi.axi_r_resp  = 2'b10;
        tick();
        axi.axi_r_valid = 1'b0;
        check_eq("r1_rsp_ready", 64'(reg_bus.reg_rsp_ready), 64'd1);
        check_eq("r1_rsp_rdata", reg_bus.reg_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        check_eq("r1_rsp_error", 64'(reg_bus.reg_rsp_error), 64'd1);
        reg_bus.reg_req_valid = 1'b0;
        tick();
        exp_tag = 2'd2;

`ifdef REG_TO_AXI_TIMEOUT_EN
        // Read never accepted: timeout after 16 busy cycles.
        set_req(64'h3000, 64'd0, 8'h00, 1'b0);
        tick();
        n = 0;
        while (!reg_bus.reg_rsp_ready && n < 40) begin
            tick();
            n++;
        end
        check_eq("tmo_cycles", 64'(n), 64'd16);
        check_eq("tmo_ar_valid", 64'(axi.axi_ar_valid), 64'd0);
        check_eq("tmo_error", 64'(reg_bus.reg_rsp_error), 64'd1);
        check_eq("tmo_rdata", reg_bus.reg_rsp_rdata, 64'd0);
        reg_bus.reg_req_valid = 1'b0;
        tick();
        exp_tag = 2'd3;
`endif

        // Stale R with the previous tag is consumed; matching R completes.
        set_req(64'h2000, 64'd0, 8'h00, 1'b0);
        tick();
        check_eq("r2_ar_id", 64'(axi.axi_ar_id), 64'(exp_tag));
        axi.axi_ar_ready = 1'b1;
        tick();
        axi.axi_ar_ready = 1'b0;
        axi.axi_r_valid = 1'b1;
        axi.axi_r_id    = exp_tag - 2'd1;
        axi.axi_r_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        axi.axi_r_resp  = 2'b10;
        check_eq("r2_stale_r_ready", 64'(axi.axi_r_ready), 64'd1);
        tick();
        check_eq("r2_stale_ignored", 64'(reg_bus.reg_rsp_ready), 64'd0);
        axi.axi_r_id   = exp_tag;
        axi.axi_r_data = 64'hA5A5_5A5A_0F0F_F0F0;
        axi.axi_r_resp = 2'b00;
        tick();
        axi.axi_r_valid = 1'b0;
        check_eq("r2_rsp_ready", 64'(reg_bus.reg_rsp_ready), 64'd1);
        check_eq("r2_rsp_rdata", reg_bus.reg_rsp_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        check_eq("r2_rsp_error", 64'(reg_bus.reg_rsp_error), 64'd0);
        reg_bus.reg_req_valid = 1'b0;
        tick();
        exp_tag = exp_tag + 2'd1;

        // Reset while waiting for B: transaction abandoned, stale B discarded.
        set_req(64'h80, 64'h1111, 8'h01, 1'b1);
        tick();
        axi.axi_aw_ready = 1'b1;
        axi.axi_w_ready  = 1'b1;
        tick();
        axi.axi_aw_ready = 1'b0;
        axi.axi_w_ready  = 1'b0;
        p = pulse_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reg_bus.reg_req_valid = 1'b0;
        check_idle_outputs("midrst");
        axi.axi_b_valid = 1'b1;
        axi.axi_b_id    = exp_tag;
        axi.axi_b_resp  = 2'b00;
        tick();
        axi.axi_b_valid = 1'b0;
        check_eq("midrst_stale_b", 64'(reg_bus.reg_rsp_ready), 64'd0);
        tick();
        check_eq("midrst_no_pulse", 64'(pulse_cnt), 64'(p));

        // Five back-to-back writes: tags restart at 0 and wrap after 3.
        for (int i = 0; i < 5; i++) begin
            do_write(64'h100 + 64'(i * 8), (i == 2) ? 2'b10 : 2'b00, 2'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
